// File: rtl/rv_constants.sv
// Shared RV core constants: controller PC-select encodings, reset PC and the
// fetch FSM state type.
package rv_constants;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] CFG_RESET_PC = 32'h0040_0000;

  localparam logic [1:0] CTL_PC_PC4     = 2'b00;
  localparam logic [1:0] CTL_PC_PC_IMM  = 2'b01;
  localparam logic [1:0] CTL_PC_RS1_IMM = 2'b10;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Instruction addresses must be word aligned.
  function automatic logic pc_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, holds the
// fetched word until the core accepts it, then steers to the next PC.
module instruction_fetch_unit
  import rv_constants::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(CFG_RESET_PC)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic [31:0]           inst,
  output logic [6:0]            inst_opcode,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_accept,
  input  logic [1:0]            next_pc_select,
  input  logic [ADDR_WIDTH-1:0] pc_imm_target,
  input  logic [ADDR_WIDTH-1:0] rs1_imm_target,
  output logic                  fetch_fault
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc_c;

  assign imem_req_addr = pc;
  assign inst_opcode   = inst[6:0];

  // Next-PC select; the unused 2'b11 encoding falls back to sequential flow.
  always_comb begin
    next_pc_c = inst_pc + ADDR_WIDTH'(4);
    case (next_pc_select)
      CTL_PC_PC_IMM:  next_pc_c = pc_imm_target;
      CTL_PC_RS1_IMM: next_pc_c = rs1_imm_target & ~ADDR_WIDTH'(1);
      default:        next_pc_c = inst_pc + ADDR_WIDTH'(4);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      inst           <= 32'h0;
      inst_pc        <= RESET_PC;
      inst_valid     <= 1'b0;
      fetch_fault    <= 1'b0;
      imem_req_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // Request is only raised the cycle after reset, so ready is
          // honoured only once valid is actually visible to memory.
          if (!imem_req_valid) begin
            imem_req_valid <= 1'b1;
          end else if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= READY;
          end
        end
        READY: begin
          if (inst_accept) begin
            inst_valid <= 1'b0;
            pc         <= next_pc_c;
            if (pc_misaligned(next_pc_c[1:0])) begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              imem_req_valid <= 1'b1;
              state          <= FETCH;
            end
          end
        end
        FAULT: begin
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
          fetch_fault    <= 1'b1;
        end
      endcase
    end
  end

  // A response can only legally arrive while a request is outstanding.
  rsp_only_in_wait: assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> (state == WAIT))
    else $error("imem_rsp_valid outside WAIT");

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with hand-computed expectations.
module tb_instruction_fetch_unit;
  import rv_constants::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic [6:0]  inst_opcode;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_accept;
  logic [1:0]  next_pc_select;
  logic [31:0] pc_imm_target;
  logic [31:0] rs1_imm_target;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  instruction_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .inst_opcode    (inst_opcode),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_accept    (inst_accept),
    .next_pc_select (next_pc_select),
    .pc_imm_target  (pc_imm_target),
    .rs1_imm_target (rs1_imm_target),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, RST_PC);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_addr", imem_req_addr, RST_PC);
  endtask

  // Serve one fetch; returns the cycle stamp at which inst_valid is seen.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                           input int ready_delay, input int rsp_delay, output int t_valid);
    for (int i = 0; i < 8 && !imem_req_valid; i++) @(negedge clock);
    check("req_valid", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_req_addr, addr);
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clock);
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_req_addr, addr);
    end
    imem_req_ready = 1'b1;
    @(negedge clock);
    imem_req_ready = 1'b0;
    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clock);
      check("wait_inst_valid", 32'(inst_valid), 32'd0);
      check("wait_addr", imem_req_addr, addr);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clock);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    t_valid = cyc;
    check("inst_valid", 32'(inst_valid), 32'd1);
    check("inst", inst, data);
    check("inst_opcode", 32'(inst_opcode), 32'(data[6:0]));
    check("inst_pc", inst_pc, addr);
  endtask

  task automatic accept(input logic [1:0] sel, input logic [31:0] pci, input logic [31:0] rsi);
    inst_accept    = 1'b1;
    next_pc_select = sel;
    pc_imm_target  = pci;
    rs1_imm_target = rsi;
    @(negedge clock);
    inst_accept = 1'b0;
    check("accept_inst_valid", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    int t0, t1, t2;
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    inst_accept = 1'b0; next_pc_select = CTL_PC_PC4; pc_imm_target = 32'h0; rs1_imm_target = 32'h0;

    // Zero-wait sequential stream
    do_reset();
    fetch_one(RST_PC, NOP, 0, 0, t0);          accept(CTL_PC_PC4, 32'h0, 32'h0);
    fetch_one(32'h0040_0004, NOP, 0, 0, t1);   accept(CTL_PC_PC4, 32'h0, 32'h0);
    fetch_one(32'h0040_0008, NOP, 0, 0, t2);
    check("period_1", 32'(t1 - t0), 32'd3);
    check("period_2", 32'(t2 - t1), 32'd3);
    // Encoding 2'b11 behaves as PC4 regardless of targets
    accept(2'b11, 32'h0040_0800, 32'h0040_0900);
    check("sel11_addr", imem_req_addr, 32'h0040_000C);

    // Stalled memory; accept while nothing is held must be ignored
    do_reset();
    inst_accept = 1'b1; next_pc_select = CTL_PC_PC_IMM; pc_imm_target = 32'h0040_0800;
    @(negedge clock);
    inst_accept = 1'b0;
    check("idle_accept_addr", imem_req_addr, RST_PC);
    fetch_one(RST_PC, 32'h1234_5067, 4, 5, t0);
    accept(CTL_PC_PC4, 32'h0, 32'h0);

    // Branch and JALR
    fetch_one(32'h0040_0004, 32'h0000_0063, 0, 1, t0);
    accept(CTL_PC_PC_IMM, 32'h0040_0100, 32'h0);
    fetch_one(32'h0040_0100, 32'h0000_0067, 0, 0, t0);
    accept(CTL_PC_RS1_IMM, 32'h0, 32'h0040_0201);
    check("jalr_fault", 32'(fetch_fault), 32'd0);
    fetch_one(32'h0040_0200, 32'hABCD_E0B3, 1, 0, t0);

    // Hold without accept
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i % 3 == 0) begin
        check("hold_inst", inst, 32'hABCD_E0B3);
        check("hold_inst_pc", inst_pc, 32'h0040_0200);
      end
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    check("hold_valid", 32'(inst_valid), 32'd1);

    // Misaligned target enters FAULT until reset
    accept(CTL_PC_PC_IMM, 32'h0040_0102, 32'h0);
    check("fault_flag", 32'(fetch_fault), 32'd1);
    check("fault_pc", imem_req_addr, 32'h0040_0102);
    for (int i = 0; i < 20; i++) begin
      imem_req_ready = 1'b1;
      @(negedge clock);
      if (i % 4 == 0) check("fault_no_req", 32'(imem_req_valid), 32'd0);
    end
    imem_req_ready = 1'b0;
    check("fault_inst_valid", 32'(inst_valid), 32'd0);
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    do_reset();

    // Reset while a response is pending
    imem_req_ready = 1'b1;
    @(negedge clock);
    imem_req_ready = 1'b0;
    check("pre_rst_wait", 32'(imem_req_valid), 32'd0);
    do_reset();
    check("wait_rst_inst_valid", 32'(inst_valid), 32'd0);

    // Address wrap from the top of the address space
    fetch_one(RST_PC, NOP, 0, 0, t0);
    accept(CTL_PC_PC_IMM, 32'hFFFF_FFFC, 32'h0);
    fetch_one(32'hFFFF_FFFC, NOP, 0, 0, t0);
    accept(CTL_PC_PC4, 32'h0, 32'h0);
    check("wrap_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_addr", imem_req_addr, 32'h0);
    check("wrap_fault", 32'(fetch_fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
